fofb_readout_scheduler: RTL and testbench

FOFB_READOUT_SCHEDULER -- requirements
Module: fofb_readout_scheduler

---
 rtl/fofb_readout_scheduler.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fofb_readout_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fofb_readout_scheduler.sv
// -----------------------------------------------------------------------------
// fofb_readout_scheduler
//
// Shares the single read port of the per-BPM readout DPRAM between a sweep
// engine (reads BPM indices 0..sweepCount-1 in order, one per cycle) and an
// occasional host read. Sweep traffic has priority. At most one read is issued
// per cycle.
//
// A read is issued in cycle N, when readoutAddress (a register) carries its
// address. The DPRAM returns data in N+1. The data is registered, so the
// result outputs are valid in N+2.
//
// Build option:
//   HOST_SLOT_EN - when defined, every HOST_SLOT_PERIOD-th sweep issue cycle is
//                  handed to a pending host read (the sweep stalls for one
//                  cycle). When undefined, a host read waits until the sweep
//                  has nothing left to issue.
//
// Ports:
//   sysClk, sysReset            clock, asynchronous active-high reset
//   sweepStart, sweepCount      start pulse and number of BPMs to sweep
//   sweepBusy, sweepDone        sweep in progress / completion pulse
//   sweepValid, sweepIndex,
//   sweepX/Y/S                  swept result stream
//   hostReq, hostAddress        level host read request and its index
//   hostAck, hostX/Y/S          host completion pulse and held result
//   readoutAddress              registered DPRAM read address
//   readoutX/Y/S                DPRAM read data (one cycle after address)
// -----------------------------------------------------------------------------
module fofb_readout_scheduler #(
    parameter int FOFB_INDEX_WIDTH = 9,
    parameter int HOST_SLOT_PERIOD = 16
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        sweepStart,
    input  logic [FOFB_INDEX_WIDTH:0]   sweepCount,
    output logic                        sweepBusy,
    output logic                        sweepDone,
    output logic                        sweepValid,
    output logic [FOFB_INDEX_WIDTH-1:0] sweepIndex,
    output logic [31:0]                 sweepX,
    output logic [31:0]                 sweepY,
    output logic [31:0]                 sweepS,
    input  logic                        hostReq,
    input  logic [FOFB_INDEX_WIDTH-1:0] hostAddress,
    output logic                        hostAck,
    output logic [31:0]                 hostX,
    output logic [31:0]                 hostY,
    output logic [31:0]                 hostS,
    output logic [FOFB_INDEX_WIDTH-1:0] readoutAddress,
    input  logic [31:0]                 readoutX,
    input  logic [31:0]                 readoutY,
    input  logic [31:0]                 readoutS
);

    localparam int CW = FOFB_INDEX_WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                      state_r;
    // Counters are one bit wider than the index so a full-table sweep
    // (sweepCount = 2^FOFB_INDEX_WIDTH) terminates without wrapping.
    logic [CW-1:0]               sweepCnt_r;
    logic [CW-1:0]               sweepPtr_r;
    logic                        hostArmed_r;

    // Tags travelling alongside each issued read: stage 1 is the issue cycle,
    // stage 2 the cycle the DPRAM data is on readoutX/Y/S.
    logic                        tag1Sweep_r;
    logic                        tag1Host_r;
    logic                        tag1Last_r;
    logic [FOFB_INDEX_WIDTH-1:0] tag1Index_r;
    logic                        tag2Sweep_r;
    logic                        tag2Host_r;
    logic                        tag2Last_r;
    logic [FOFB_INDEX_WIDTH-1:0] tag2Index_r;

    logic                        hostPending_s;
    logic                        sweepRemain_s;
    logic                        startAccept_s;
    logic                        startEmpty_s;
    logic                        slotReserved_s;
    logic                        issueSweep_s;
    logic                        issueHost_s;
    logic                        issueLast_s;
    logic [FOFB_INDEX_WIDTH-1:0] issueAddr_s;

`ifdef HOST_SLOT_EN
    localparam int SW = $clog2(HOST_SLOT_PERIOD + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(HOST_SLOT_PERIOD - 1);

    // Position of the current sweep issue cycle within the reservation period.
    logic [SW-1:0] slotCnt_r;

    // A reserved slot only matters when a host read is actually waiting.
    always_comb begin
        slotReserved_s = sweepRemain_s && hostPending_s && (slotCnt_r == SLOT_LAST);
    end

    // Count sweep issue cycles; the count restarts with every accepted sweep.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            slotCnt_r <= {SW{1'b0}};
        end else if (startAccept_s) begin
            slotCnt_r <= issueSweep_s ? SW'(1) : {SW{1'b0}};
        end else if (sweepRemain_s) begin
            slotCnt_r <= (slotCnt_r == SLOT_LAST) ? {SW{1'b0}} : slotCnt_r + SW'(1);
        end else begin
            slotCnt_r <= slotCnt_r;
        end
    end
`else
    // Without reservation the sweep is never stalled.
    always_comb begin
        slotReserved_s = 1'b0;
    end
`endif

    // Arbitration of the single DPRAM read port for this cycle.
    always_comb begin
        hostPending_s = hostReq && hostArmed_r && !tag1Host_r && !tag2Host_r;
        sweepRemain_s = (state_r == SWEEP) && (sweepPtr_r < sweepCnt_r);
        startAccept_s = (state_r == IDLE) && sweepStart && (sweepCount != {CW{1'b0}});
        startEmpty_s  = (state_r == IDLE) && sweepStart && (sweepCount == {CW{1'b0}});
        issueSweep_s  = 1'b0;
        issueHost_s   = 1'b0;
        issueLast_s   = 1'b0;
        issueAddr_s   = readoutAddress;
        if (sweepRemain_s && !slotReserved_s) begin
            issueSweep_s = 1'b1;
            issueAddr_s  = sweepPtr_r[FOFB_INDEX_WIDTH-1:0];
            issueLast_s  = (sweepPtr_r == (sweepCnt_r - CW'(1)));
        end else if (hostPending_s) begin
            // A host request pending in the start cycle takes that cycle;
            // the sweep then begins with index 0 on the following cycle.
            issueHost_s  = 1'b1;
            issueAddr_s  = hostAddress;
        end else if (startAccept_s) begin
            issueSweep_s = 1'b1;
            issueAddr_s  = {FOFB_INDEX_WIDTH{1'b0}};
            issueLast_s  = (sweepCount == CW'(1));
        end else begin
            issueSweep_s = 1'b0;
        end
    end

    // Sweep control FSM, host arming, read address and read tag pipeline.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state_r        <= IDLE;
            sweepBusy      <= 1'b0;
            sweepCnt_r     <= {CW{1'b0}};
            sweepPtr_r     <= {CW{1'b0}};
            hostArmed_r    <= 1'b1;
            readoutAddress <= {FOFB_INDEX_WIDTH{1'b0}};
            tag1Sweep_r    <= 1'b0;
            tag1Host_r     <= 1'b0;
            tag1Last_r     <= 1'b0;
            tag1Index_r    <= {FOFB_INDEX_WIDTH{1'b0}};
            tag2Sweep_r    <= 1'b0;
            tag2Host_r     <= 1'b0;
            tag2Last_r     <= 1'b0;
            tag2Index_r    <= {FOFB_INDEX_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (startAccept_s) begin
                        state_r    <= SWEEP;
                        sweepBusy  <= 1'b1;
                        sweepCnt_r <= sweepCount;
                        sweepPtr_r <= issueSweep_s ? CW'(1) : {CW{1'b0}};
                    end else begin
                        state_r    <= IDLE;
                        sweepBusy  <= 1'b0;
                    end
                end
                SWEEP: begin
                    // Stay busy through the cycle that shows sweepDone.
                    if (sweepDone) begin
                        state_r   <= IDLE;
                        sweepBusy <= 1'b0;
                    end else begin
                        state_r   <= SWEEP;
                        sweepBusy <= 1'b1;
                    end
                    if (issueSweep_s) begin
                        sweepPtr_r <= sweepPtr_r + CW'(1);
                    end else begin
                        sweepPtr_r <= sweepPtr_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    sweepBusy <= 1'b0;
                end
            endcase

            // One read per hostReq assertion: re-arm only once hostReq is seen low.
            if (issueHost_s) begin
                hostArmed_r <= 1'b0;
            end else if (!hostReq) begin
                hostArmed_r <= 1'b1;
            end else begin
                hostArmed_r <= hostArmed_r;
            end

            readoutAddress <= issueAddr_s;
            tag1Sweep_r    <= issueSweep_s;
            tag1Host_r     <= issueHost_s;
            tag1Last_r     <= issueLast_s;
            tag1Index_r    <= issueAddr_s;
            tag2Sweep_r    <= tag1Sweep_r;
            tag2Host_r     <= tag1Host_r;
            tag2Last_r     <= tag1Last_r;
            tag2Index_r    <= tag1Index_r;
        end
    end

    // Result registers: capture DPRAM data for the read whose tag is in stage 2.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            sweepValid <= 1'b0;
            sweepDone  <= 1'b0;
            sweepIndex <= {FOFB_INDEX_WIDTH{1'b0}};
            sweepX     <= 32'h0000_0000;
            sweepY     <= 32'h0000_0000;
            sweepS     <= 32'h0000_0000;
            hostAck    <= 1'b0;
            hostX      <= 32'h0000_0000;
            hostY      <= 32'h0000_0000;
            hostS      <= 32'h0000_0000;
        end else begin
            sweepValid <= tag2Sweep_r;
            // An empty sweep completes on the cycle after its start pulse.
            sweepDone  <= (tag2Sweep_r && tag2Last_r) || startEmpty_s;
            hostAck    <= tag2Host_r;
            if (tag2Sweep_r) begin
                sweepIndex <= tag2Index_r;
                sweepX     <= readoutX;
                sweepY     <= readoutY;
                sweepS     <= readoutS;
            end else begin
                sweepIndex <= sweepIndex;
                sweepX     <= sweepX;
                sweepY     <= sweepY;
                sweepS     <= sweepS;
            end
            if (tag2Host_r) begin
                hostX <= readoutX;
                hostY <= readoutY;
                hostS <= readoutS;
            end else begin
                hostX <= hostX;
                hostY <= hostY;
                hostS <= hostS;
            end
        end
    end

endmodule

// File: tb/tb_fofb_readout_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fofb_readout_scheduler
//
// Self-checking bench for fofb_readout_scheduler. A behavioural DPRAM returns
// index-derived data one cycle after the address. Expected sweep indices and
// host addresses are queued when stimulus is driven and checked as the DUT
// produces sweepValid / hostAck. Plain sweeps come from a vector table; host,
// restart, full-table and reset corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fofb_readout_scheduler;

    localparam int W = 9;

    logic          sysClk = 1'b0;
    logic          sysReset;
    logic          sweepStart;
    logic [W:0]    sweepCount;
    logic          sweepBusy;
    logic          sweepDone;
    logic          sweepValid;
    logic [W-1:0]  sweepIndex;
    logic [31:0]   sweepX, sweepY, sweepS;
    logic          hostReq;
    logic [W-1:0]  hostAddress;
    logic          hostAck;
    logic [31:0]   hostX, hostY, hostS;
    logic [W-1:0]  readoutAddress;
    logic [31:0]   readoutX, readoutY, readoutS;
    logic [W-1:0]  ramAddr = '0;

    always #5 sysClk = ~sysClk;

    fofb_readout_scheduler #(.FOFB_INDEX_WIDTH(W), .HOST_SLOT_PERIOD(16)) dut (
        .sysClk(sysClk), .sysReset(sysReset),
        .sweepStart(sweepStart), .sweepCount(sweepCount),
        .sweepBusy(sweepBusy), .sweepDone(sweepDone), .sweepValid(sweepValid),
        .sweepIndex(sweepIndex), .sweepX(sweepX), .sweepY(sweepY), .sweepS(sweepS),
        .hostReq(hostReq), .hostAddress(hostAddress), .hostAck(hostAck),
        .hostX(hostX), .hostY(hostY), .hostS(hostS),
        .readoutAddress(readoutAddress),
        .readoutX(readoutX), .readoutY(readoutY), .readoutS(readoutS)
    );

    function automatic logic [31:0] mx(int i); return 32'(i); endfunction
    function automatic logic [31:0] my(int i); return 32'(i) ^ 32'h5A5A_0000; endfunction
    function automatic logic [31:0] ms(int i); return 32'(i) + 32'h1234_0000; endfunction

    // DPRAM model: data for the address presented in the previous cycle.
    always @(posedge sysClk) ramAddr <= readoutAddress;
    assign readoutX = mx(int'(ramAddr));
    assign readoutY = my(int'(ramAddr));
    assign readoutS = ms(int'(ramAddr));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int refCyc, hostRefCyc;
    int validCnt, firstValidLat, doneCnt, doneLat, doneCyc, doneIdx;
    int ackCnt, ackLat, ackCyc;
    logic busySeen, busyAtDone, doneValid;
    int lastIdx = 0;
    int sbSweep[$];
    int sbHost[$];

    typedef struct {
        int count;
        int firstLat;
        int doneLat;
        int nValid;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and check whatever the DUT produced in it.
    task automatic step();
        int e;
        @(posedge sysClk);
        #1;
        cyc++;
        if (sweepValid) begin
            validCnt++;
            if (firstValidLat < 0) firstValidLat = cyc - refCyc;
            chk("sweepValid expected", 32'(sbSweep.size() > 0), 32'd1);
            if (sbSweep.size() > 0) begin
                e = sbSweep.pop_front();
                chk("sweepIndex", 32'(sweepIndex), 32'(e));
                chk("sweepX", sweepX, mx(e));
                chk("sweepY", sweepY, my(e));
                chk("sweepS", sweepS, ms(e));
                lastIdx = e;
            end
        end else begin
            chk("sweepIndex hold", 32'(sweepIndex), 32'(lastIdx));
        end
        if (sweepBusy) busySeen = 1'b1;
        if (sweepDone) begin
            doneCnt++;
            doneLat = cyc - refCyc;
            doneCyc = cyc;
            busyAtDone = sweepBusy;
            doneValid = sweepValid;
            doneIdx = int'(sweepIndex);
        end
        if (hostAck) begin
            ackCnt++;
            ackLat = cyc - hostRefCyc;
            ackCyc = cyc;
            chk("hostAck expected", 32'(sbHost.size() > 0), 32'd1);
            if (sbHost.size() > 0) begin
                e = sbHost.pop_front();
                chk("hostX", hostX, mx(e));
                chk("hostY", hostY, my(e));
                chk("hostS", hostS, ms(e));
            end
        end
    endtask

    task automatic startSweep(int n);
        sweepCount = (W+1)'(n);
        sweepStart = 1'b1;
        refCyc = cyc;
        validCnt = 0; firstValidLat = -1;
        doneCnt = 0; doneLat = -1; doneCyc = -1;
        busySeen = 1'b0;
        for (int i = 0; i < n; i++) sbSweep.push_back(i);
        step();
        sweepStart = 1'b0;
    endtask

    task automatic hostStart(int a);
        hostAddress = W'(a);
        hostReq = 1'b1;
        hostRefCyc = cyc;
        ackCnt = 0; ackLat = -1; ackCyc = -1;
        sbHost.push_back(a);
    endtask

    task automatic waitDone(int budget);
        for (int k = 0; k < budget && doneCnt == 0; k++) step();
        chk("sweepDone within budget", 32'(doneCnt > 0), 32'd1);
    endtask

    initial begin
        logic found;
        vecs[0] = '{count: 4, firstLat: 3,  doneLat: 6, nValid: 4};
        vecs[1] = '{count: 1, firstLat: 3,  doneLat: 3, nValid: 1};
        vecs[2] = '{count: 0, firstLat: -1, doneLat: 1, nValid: 0};
        vecs[3] = '{count: 7, firstLat: 3,  doneLat: 9, nValid: 7};
        vecs[4] = '{count: 2, firstLat: 3,  doneLat: 4, nValid: 2};

        sysReset = 1'b1; sweepStart = 1'b0; sweepCount = '0;
        hostReq = 1'b0; hostAddress = '0;
        refCyc = 0; hostRefCyc = 0; ackCnt = 0; doneCnt = 0;
        validCnt = 0; firstValidLat = -1;
        step(); step();
        chk("reset readoutAddress", 32'(readoutAddress), 32'd0);
        chk("reset sweepBusy", 32'(sweepBusy), 32'd0);
        chk("reset sweepDone", 32'(sweepDone), 32'd0);
        chk("reset sweepValid", 32'(sweepValid), 32'd0);
        chk("reset hostAck", 32'(hostAck), 32'd0);
        chk("reset sweepX", sweepX, 32'd0);
        chk("reset hostS", hostS, 32'd0);
        sysReset = 1'b0;
        step();

        // Table-driven plain sweeps, host idle.
        foreach (vecs[v]) begin
            startSweep(vecs[v].count);
            waitDone(600);
            chk("first valid latency", 32'(firstValidLat), 32'(vecs[v].firstLat));
            chk("done latency", 32'(doneLat), 32'(vecs[v].doneLat));
            chk("valid count", 32'(validCnt), 32'(vecs[v].nValid));
            chk("busy at done", 32'(busyAtDone), 32'(vecs[v].count > 0));
            chk("busy ever high", 32'(busySeen), 32'(vecs[v].count > 0));
            chk("valid with done", 32'(doneValid), 32'(vecs[v].count > 0));
            if (vecs[v].count > 0) chk("index at done", 32'(doneIdx), 32'(vecs[v].count - 1));
            step();
            chk("busy after done", 32'(sweepBusy), 32'd0);
            step(); step();
            chk("single sweepDone", 32'(doneCnt), 32'd1);
            chk("sweep scoreboard drained", 32'(sbSweep.size()), 32'd0);
        end

        // Host read while idle, request held for 10 cycles.
        hostStart(5);
        step();
        chk("host issue address", 32'(readoutAddress), 32'd5);
        for (int k = 0; k < 9; k++) step();
        hostReq = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("host ack count", 32'(ackCnt), 32'd1);
        chk("host ack latency", 32'(ackLat), 32'd3);
        chk("hostX held", hostX, mx(5));

        // Start and host request in the same idle cycle: host goes first.
        hostStart(9);
        startSweep(2);
        chk("simultaneous host issue", 32'(readoutAddress), 32'd9);
        hostReq = 1'b0;
        step();
        chk("sweep first issue", 32'(readoutAddress), 32'd0);
        step();
        chk("sweep second issue", 32'(readoutAddress), 32'd1);
        waitDone(50);
        chk("delayed first valid", 32'(firstValidLat), 32'd4);
        chk("delayed done latency", 32'(doneLat), 32'd5);
        chk("simultaneous ack latency", 32'(ackLat), 32'd3);
        chk("simultaneous ack count", 32'(ackCnt), 32'd1);
        step(); step();

        // Re-pulsed start while busy is ignored.
        startSweep(8);
        step(); step();
        sweepCount = 10'd3;
        sweepStart = 1'b1;
        step();
        sweepStart = 1'b0;
        waitDone(50);
        for (int k = 0; k < 5; k++) step();
        chk("restart valid count", 32'(validCnt), 32'd8);
        chk("restart done latency", 32'(doneLat), 32'd10);
        chk("restart single done", 32'(doneCnt), 32'd1);

        // Full-table sweep with a host request arriving mid-sweep.
        startSweep(512);
        for (int k = 0; k < 9; k++) step();
        hostStart(7);
        for (int k = 0; k < 700 && !(doneCnt > 0 && ackCnt > 0); k++) begin
            step();
            if (ackCnt > 0) hostReq = 1'b0;
        end
        hostReq = 1'b0;
        chk("full sweep valid count", 32'(validCnt), 32'd512);
        chk("full sweep drained", 32'(sbSweep.size()), 32'd0);
        chk("full sweep host acks", 32'(ackCnt), 32'd1);
        chk("full sweep index at done", 32'(doneIdx), 32'd511);
`ifdef HOST_SLOT_EN
        chk("host within 18 cycles", 32'(ackLat >= 3 && ackLat <= 18), 32'd1);
        chk("full sweep done latency", 32'(doneLat), 32'd515);
`else
        chk("host after sweepDone", 32'(ackCyc > doneCyc), 32'd1);
        chk("full sweep done latency", 32'(doneLat), 32'd514);
`endif
        for (int k = 0; k < 4; k++) step();

        // Reset in the middle of a sweep, then a clean sweep.
        startSweep(200);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (sweepValid && sweepIndex == W'(100)) found = 1'b1;
        end
        chk("reached index 100", 32'(found), 32'd1);
        sysReset = 1'b1;
        #1;
        chk("reset sweepValid now", 32'(sweepValid), 32'd0);
        chk("reset sweepIndex now", 32'(sweepIndex), 32'd0);
        chk("reset sweepX now", sweepX, 32'd0);
        chk("reset sweepBusy now", 32'(sweepBusy), 32'd0);
        chk("reset readoutAddress now", 32'(readoutAddress), 32'd0);
        sbSweep.delete();
        lastIdx = 0;
        doneCnt = 0;
        step(); step();
        sysReset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("no done after reset", 32'(doneCnt), 32'd0);
        chk("idle after reset", 32'(sweepBusy), 32'd0);
        startSweep(4);
        waitDone(50);
        chk("post-reset valid count", 32'(validCnt), 32'd4);
        chk("post-reset done latency", 32'(doneLat), 32'd6);
        chk("post-reset first valid", 32'(firstValidLat), 32'd3);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
